// File: rtl/round_ctrl_if.sv
// Spawn-block handshake between round_ctrl (master) and the ball spawn block (slave).
interface round_ctrl_if;
    logic       ibsEnable;
    logic [2:0] spawnColl;
    logic       ibsDone;

    modport master (output ibsEnable, output spawnColl, input ibsDone);
    modport slave  (input ibsEnable, input spawnColl, output ibsDone);
endinterface

// File: rtl/round_ctrl.sv
// round_ctrl: game round sequencer (spawn, serve delay, play, scoring, game over).
// Optional ROUND_CTRL_PAUSE_EN adds a pause input that freezes serve countdown and play.
module round_ctrl #(
    parameter int unsigned WIN_SCORE   = 7,
    parameter int unsigned SERVE_DELAY = 60
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         gameStart,
    input  logic         frameTick,
    input  logic [2:0]   SEColl,
`ifdef ROUND_CTRL_PAUSE_EN
    input  logic         pause,
`endif
    round_ctrl_if.master spawn,
    output logic         ballRun,
    output logic [3:0]   scoreL,
    output logic [3:0]   scoreR,
    output logic [1:0]   winner,
    output logic         gameOver,
    output logic [2:0]   stateOut
);

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StSpawn     = 3'd1,
        StServeWait = 3'd2,
        StPlay      = 3'd3,
        StScore     = 3'd4,
        StOver      = 3'd5
    } state_t;

    localparam logic [2:0] EdgeLeft   = 3'b100;
    localparam logic [2:0] EdgeRight  = 3'b010;
    localparam logic [8:0] ServeDelay = 9'(SERVE_DELAY);
    localparam logic [3:0] WinScore   = 4'(WIN_SCORE);

    state_t     state_q, state_d;
    logic       start_dly_q, start_armed_q;
    logic [7:0] serve_cnt_q, serve_cnt_d;
    logic [3:0] score_l_q, score_l_d, score_r_q, score_r_d;
    logic [2:0] coll_q, coll_d;
    logic [1:0] winner_q, winner_d;
    logic       start_edge, paused;
    logic [8:0] cnt_inc;
    logic [3:0] score_l_inc, score_r_inc;

    // Armed only after gameStart is seen low, so a level held through reset never starts a game.
    assign start_edge  = gameStart & ~start_dly_q & start_armed_q;
    assign cnt_inc     = {1'b0, serve_cnt_q} + 9'd1;
    assign score_l_inc = (score_l_q == 4'hF) ? 4'hF : score_l_q + 4'd1;
    assign score_r_inc = (score_r_q == 4'hF) ? 4'hF : score_r_q + 4'd1;

`ifdef ROUND_CTRL_PAUSE_EN
    logic pause_dly_q, paused_q, paused_d;

    always_comb begin
        paused_d = paused_q;
        if ((state_q == StServeWait || state_q == StPlay) && pause && !pause_dly_q) begin
            paused_d = ~paused_q;
        end
        if (state_d != StServeWait && state_d != StPlay) begin
            paused_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pause_dly_q <= 1'b0;
            paused_q    <= 1'b0;
        end else begin
            pause_dly_q <= pause;
            paused_q    <= paused_d;
        end
    end

    assign paused = paused_q;
`else
    assign paused = 1'b0;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= StIdle;
            start_dly_q   <= 1'b0;
            start_armed_q <= 1'b0;
            serve_cnt_q   <= 8'd0;
            score_l_q     <= 4'd0;
            score_r_q     <= 4'd0;
            coll_q        <= 3'b000;
            winner_q      <= 2'b00;
        end else begin
            state_q       <= state_d;
            start_dly_q   <= gameStart;
            start_armed_q <= start_armed_q | ~gameStart;
            serve_cnt_q   <= serve_cnt_d;
            score_l_q     <= score_l_d;
            score_r_q     <= score_r_d;
            coll_q        <= coll_d;
            winner_q      <= winner_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        serve_cnt_d = 8'd0;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        coll_d      = coll_q;
        winner_d    = winner_q;
        case (state_q)
            StIdle, StOver: begin
                if (start_edge) begin
                    state_d   = StSpawn;
                    score_l_d = 4'd0;
                    score_r_d = 4'd0;
                    coll_d    = 3'b000;
                    winner_d  = 2'b00;
                end
            end
            StSpawn: begin
                if (spawn.ibsDone) state_d = StServeWait;
            end
            StServeWait: begin
                serve_cnt_d = serve_cnt_q;
                if (!paused) begin
                    if (ServeDelay == 9'd0) begin
                        state_d = StPlay;
                    end else if (frameTick) begin
                        if (cnt_inc == ServeDelay) state_d = StPlay;
                        else serve_cnt_d = cnt_inc[7:0];
                    end
                end
            end
            StPlay: begin
                if (!paused && (SEColl == EdgeLeft || SEColl == EdgeRight)) begin
                    coll_d  = SEColl;
                    state_d = StScore;
                end
            end
            StScore: begin
                // Ball reaching the right edge is a point for the left player.
                if (coll_q == EdgeRight) begin
                    score_l_d = score_l_inc;
                    if (score_l_inc == WinScore) begin
                        state_d  = StOver;
                        winner_d = 2'b01;
                    end else begin
                        state_d = StSpawn;
                    end
                end else begin
                    score_r_d = score_r_inc;
                    if (score_r_inc == WinScore) begin
                        state_d  = StOver;
                        winner_d = 2'b10;
                    end else begin
                        state_d = StSpawn;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        spawn.ibsEnable = (state_q == StSpawn);
        ballRun         = (state_q == StPlay) && !paused;
        gameOver        = (state_q == StOver);
        stateOut        = state_q;
    end

    assign spawn.spawnColl = coll_q;
    assign scoreL          = score_l_q;
    assign scoreR          = score_r_q;
    assign winner          = winner_q;

endmodule

// File: tb/tb_round_ctrl.sv
// Directed self-checking bench for round_ctrl: DUT a (WIN_SCORE=2, SERVE_DELAY=3),
// DUT b (WIN_SCORE=7, SERVE_DELAY=0) sharing the same stimulus.
module tb_round_ctrl;
    logic       clock = 1'b0;
    logic       resetn;
    logic       gameStart, frameTick, ibs_done;
    logic [2:0] SEColl;
    logic       pause;
    logic       a_ball, a_over, b_ball, b_over;
    logic [3:0] a_sl, a_sr, b_sl, b_sr;
    logic [1:0] a_win, b_win;
    logic [2:0] a_st, b_st;
    int         n_checks = 0;
    int         n_fails  = 0;

    round_ctrl_if ifa ();
    round_ctrl_if ifb ();
    assign ifa.ibsDone = ibs_done;
    assign ifb.ibsDone = ibs_done;

    always #5 clock = ~clock;

    round_ctrl #(.WIN_SCORE(2), .SERVE_DELAY(3)) dut_a (
        .clock(clock), .resetn(resetn), .gameStart(gameStart), .frameTick(frameTick),
        .SEColl(SEColl),
`ifdef ROUND_CTRL_PAUSE_EN
        .pause(pause),
`endif
        .spawn(ifa.master), .ballRun(a_ball), .scoreL(a_sl), .scoreR(a_sr),
        .winner(a_win), .gameOver(a_over), .stateOut(a_st)
    );

    round_ctrl #(.WIN_SCORE(7), .SERVE_DELAY(0)) dut_b (
        .clock(clock), .resetn(resetn), .gameStart(gameStart), .frameTick(frameTick),
        .SEColl(SEColl),
`ifdef ROUND_CTRL_PAUSE_EN
        .pause(pause),
`endif
        .spawn(ifb.master), .ballRun(b_ball), .scoreL(b_sl), .scoreR(b_sr),
        .winner(b_win), .gameOver(b_over), .stateOut(b_st)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Three frame ticks, each followed by an idle cycle except the last.
    task automatic serve3();
        for (int i = 0; i < 3; i++) begin
            frameTick = 1'b1;
            step();
            frameTick = 1'b0;
            if (i < 2) step();
        end
    endtask

    initial begin
        resetn = 1'b0; gameStart = 1'b1; frameTick = 1'b0; ibs_done = 1'b0;
        SEColl = 3'b000; pause = 1'b0;
        step(); step();
        check("rst_state", a_st, 0);
        check("rst_outs", {a_ball, a_over, a_win, a_sl, a_sr, ifa.ibsEnable, ifa.spawnColl}, 0);

        // gameStart already high when reset releases must not start.
        resetn = 1'b1;
        step(); step(); step();
        check("no_start_held", a_st, 0);

        gameStart = 1'b0; step();
        gameStart = 1'b1; step();
        check("start_state", a_st, 1);
        check("start_ibsen", ifa.ibsEnable, 1);
        check("start_coll", ifa.spawnColl, 0);

        // Tick coincident with entry into serve-wait is not counted.
        ibs_done = 1'b1; frameTick = 1'b1; step();
        ibs_done = 1'b0; frameTick = 1'b0;
        check("sw_state", a_st, 2);
        check("sw_ibsen", ifa.ibsEnable, 0);
        frameTick = 1'b1; step(); frameTick = 1'b0; step();
        frameTick = 1'b1; step(); frameTick = 1'b0; step();
        check("sw_two_ticks", {a_st, 1'(a_ball)}, {3'd2, 1'b0});
        frameTick = 1'b1; step(); frameTick = 1'b0;
        check("play_ballrun", a_ball, 1);
        check("play_state", a_st, 3);

        SEColl = 3'b001; step();
        check("bad_code", {a_st, a_sl, a_sr}, {3'd3, 4'd0, 4'd0});
        SEColl = 3'b100; step(); SEColl = 3'b000;
        check("score_state", {a_st, 1'(a_ball)}, {3'd4, 1'b0});
        check("score_coll", ifa.spawnColl, 3'b100);
        step();
        check("after_score", {a_st, a_sl, a_sr, 1'(ifa.ibsEnable)}, {3'd1, 4'd0, 4'd1, 1'b1});

        ibs_done = 1'b1; step(); ibs_done = 1'b0;
        serve3();
        SEColl = 3'b100; step(); SEColl = 3'b000; step();
        check("over_state", a_st, 5);
        check("over_flags", {a_over, a_win, a_sr, a_sl}, {1'b1, 2'b10, 4'd2, 4'd0});
        step(); step(); step();
        check("over_hold", {a_st, a_sr}, {3'd5, 4'd2});

        gameStart = 1'b0; step();
        gameStart = 1'b1; step();
        check("restart", {a_st, a_sr, a_win, 1'(a_over), ifa.spawnColl},
              {3'd1, 4'd0, 2'b00, 1'b0, 3'b000});

        // DUT b: zero serve delay, accumulate left points, then reset mid-play.
        resetn = 1'b0; gameStart = 1'b0; step();
        resetn = 1'b1; step();
        gameStart = 1'b1; step();
        check("b_spawn", b_st, 1);
        ibs_done = 1'b1; step(); ibs_done = 1'b0;
        check("b_sw", b_st, 2);
        step();
        check("b_play_zero_delay", {b_st, 1'(b_ball)}, {3'd3, 1'b1});
        for (int i = 0; i < 3; i++) begin
            SEColl = 3'b010; step(); SEColl = 3'b000; step();
            ibs_done = 1'b1; step(); ibs_done = 1'b0; step();
        end
        check("b_scoreL3", {b_st, b_sl, b_sr, 1'(b_ball)}, {3'd3, 4'd3, 4'd0, 1'b1});
        check("b_coll", ifb.spawnColl, 3'b010);

`ifdef ROUND_CTRL_PAUSE_EN
        pause = 1'b1; step();
        check("pause_ballrun", b_ball, 0);
        SEColl = 3'b010; step(); SEColl = 3'b000;
        check("pause_ignore", {b_st, b_sl}, {3'd3, 4'd3});
        pause = 1'b0; step();
        pause = 1'b1; step(); pause = 1'b0;
        check("unpause", b_ball, 1);
`endif

        resetn = 1'b0; #1;
        check("async_rst", {b_st, b_sl, 1'(b_ball)}, {3'd0, 4'd0, 1'b0});
        check("async_rst_a", {a_st, a_sr, 1'(ifa.ibsEnable)}, {3'd0, 4'd0, 1'b0});
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
